// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the data memory: grants one access at a time,
// rejects misaligned/out-of-range commands, and sequences MemRead/MemWrite strobes.
module dmem_arbiter #(
  parameter int unsigned DM_ADDR = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        uns0,
  input  logic        uns1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic [2:0]  mem_read,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] MemReadLb  = 3'd1;
  localparam logic [2:0] MemReadLh  = 3'd2;
  localparam logic [2:0] MemReadLw  = 3'd3;
  localparam logic [2:0] MemReadLbu = 3'd4;
  localparam logic [2:0] MemReadLhu = 3'd5;
  localparam logic [1:0] MemWriteSb = 2'd1;
  localparam logic [1:0] MemWriteSh = 2'd2;
  localparam logic [1:0] MemWriteSw = 2'd3;

  // StReject stands in for ACCESS on illegal commands: gnt pulses, no strobes.
  typedef enum logic [1:0] {StIdle, StAccess, StReject, StResp} state_e;

  state_e      state_q, state_d;
  logic        win_q, last_q, we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        any_req, win_d, we_w, uns_w;
  logic [1:0]  size_w;
  logic [31:0] addr_w, wdata_w;

  function automatic logic illegal(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) ||
           (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) ||
           ((addr >> DM_ADDR) != 32'd0);
  endfunction

  // Last-granted port loses a tie; last_q resets to 1 so port 0 wins first.
  assign any_req = req0 | req1;
  assign win_d   = (req0 & req1) ? ~last_q : req1;
  assign we_w    = win_d ? we1    : we0;
  assign uns_w   = win_d ? uns1   : uns0;
  assign size_w  = win_d ? size1  : size0;
  assign addr_w  = win_d ? addr1  : addr0;
  assign wdata_w = win_d ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = illegal(size_w, addr_w) ? StReject : StAccess;
      StAccess: state_d = StResp;
      StReject: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (state_q == StIdle && any_req) begin
        win_q   <= win_d;
        we_q    <= we_w;
        uns_q   <= uns_w;
        size_q  <= size_w;
        addr_q  <= addr_w;
        wdata_q <= wdata_w;
      end
      if (state_q == StAccess && !we_q) rdata_q <= mem_rdata;
      if (state_q == StReject) rdata_q <= 32'd0;
      if (state_q == StResp) last_q <= win_q;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err       = 1'b0;
    mem_read  = 3'b000;
    mem_write = 2'b00;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    unique case (state_q)
      StAccess: begin
        gnt0      = ~win_q;
        gnt1      = win_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (we_q) begin
          case (size_q)
            2'b00:   mem_write = MemWriteSb;
            2'b01:   mem_write = MemWriteSh;
            2'b10:   mem_write = MemWriteSw;
            default: mem_write = 2'b00;
          endcase
        end else begin
          case (size_q)
            2'b00:   mem_read = uns_q ? MemReadLbu : MemReadLb;
            2'b01:   mem_read = uns_q ? MemReadLhu : MemReadLh;
            2'b10:   mem_read = MemReadLw;
            default: mem_read = 3'b000;
          endcase
        end
      end
      StReject: begin
        gnt0 = ~win_q;
        gnt1 = win_q;
      end
      StResp: begin
        done0 = ~win_q;
        done1 = win_q;
        err   = illegal(size_q, addr_q);
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory stub plus an arithmetic reference model,
// directed scenarios followed by randomized single-port accesses.
module tb_dmem_arbiter;

  localparam int unsigned DM = 16;
  localparam logic [2:0] RLb = 3'd1, RLh = 3'd2, RLw = 3'd3, RLbu = 3'd4, RLhu = 3'd5;
  localparam logic [1:0] WSb = 2'd1, WSh = 2'd2, WSw = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, uns0 = 0, uns1 = 0;
  logic [1:0]  size0 = 0, size1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 32'd0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDR(DM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stub: combinational read with extension by code, stores on negedge.
  logic [15:0] ma;
  logic [7:0]  b0, b1, b2, b3;
  always_comb begin
    ma = mem_addr[15:0];
    b0 = mem[ma];
    b1 = mem[ma + 16'd1];
    b2 = mem[ma + 16'd2];
    b3 = mem[ma + 16'd3];
    case (mem_read)
      RLb:     mem_rdata = {{24{b0[7]}}, b0};
      RLh:     mem_rdata = {{16{b1[7]}}, b1, b0};
      RLw:     mem_rdata = {b3, b2, b1, b0};
      RLbu:    mem_rdata = {24'd0, b0};
      RLhu:    mem_rdata = {16'd0, b1, b0};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(negedge clk) begin
    case (mem_write)
      WSb: mem[ma] <= mem_wdata[7:0];
      WSh: begin
        mem[ma]         <= mem_wdata[7:0];
        mem[ma + 16'd1] <= mem_wdata[15:8];
      end
      WSw: begin
        mem[ma]         <= mem_wdata[7:0];
        mem[ma + 16'd1] <= mem_wdata[15:8];
        mem[ma + 16'd2] <= mem_wdata[23:16];
        mem[ma + 16'd3] <= mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference model: byte-level arithmetic on a private copy of memory.
  function automatic bit ref_illegal(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd3) return 1'b1;
    if (a >= (32'd1 << DM)) return 1'b1;
    return (a % (32'd1 << s)) != 32'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic u,
                                           input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int n = 1 << s;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) ref_mem[a + 32'(i)] = 8'(d >> (8 * i));
  endtask

  function automatic logic [2:0] exp_rcode(input logic [1:0] s, input logic u);
    case (s)
      2'd0:    return u ? RLbu : RLb;
      2'd1:    return u ? RLhu : RLh;
      2'd2:    return RLw;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_wcode(input logic [1:0] s);
    case (s)
      2'd0:    return WSb;
      2'd1:    return WSh;
      2'd2:    return WSw;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("invariants", {29'd0, (mem_read != 3'd0) && (mem_write != 2'd0),
                           gnt0 & gnt1, done0 & done1}, 32'd0);
    end
  end

  // One access on port p, entering with the arbiter idle; checks exact latency.
  task automatic do_access(input int p, input bit we, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
    bit bad = ref_illegal(s, a);
    @(posedge clk); #1;
    if (p == 0) begin
      req0 = 1; we0 = we; size0 = s; uns0 = u; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1; we1 = we; size1 = s; uns1 = u; addr1 = a; wdata1 = d;
    end
    if (bad) exp_rd = 32'd0;
    else if (!we) exp_rd = ref_load(s, u, a);
    @(posedge clk);
    @(negedge clk);
    check("gnt_own", {31'd0, p == 0 ? gnt0 : gnt1}, 32'd1);
    check("gnt_other", {31'd0, p == 0 ? gnt1 : gnt0}, 32'd0);
    check("mem_read", {29'd0, mem_read}, (bad || we) ? 32'd0 : {29'd0, exp_rcode(s, u)});
    check("mem_write", {30'd0, mem_write}, (bad || !we) ? 32'd0 : {30'd0, exp_wcode(s)});
    if (!bad) check("mem_addr", mem_addr, a);
    if (!bad && we) begin
      check("mem_wdata", mem_wdata, d);
      ref_store(s, a, d);
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    check("done_own", {31'd0, p == 0 ? done0 : done1}, 32'd1);
    check("done_other", {31'd0, p == 0 ? done1 : done0}, 32'd0);
    check("err", {31'd0, err}, {31'd0, bad});
    check("rdata", rdata, exp_rd);
  endtask

  // Both ports request loads (port0 @0x10, port1 @0x20) until cnt grants are seen.
  task automatic both_req(input int cnt, output logic [3:0] bits, output int n);
    bits = 4'd0;
    n = 0;
    @(posedge clk); #1;
    req0 = 1; we0 = 0; size0 = 2'd2; uns0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; size1 = 2'd2; uns1 = 0; addr1 = 32'h20;
    for (int c = 0; c < 8 * cnt && n < cnt; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        bits[n] = gnt1;
        n++;
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 0; req0 = 0; req1 = 0;
    #1;
    check("rst_outs", {gnt0, gnt1, done0, done1, err, mem_read, mem_write, 23'd0}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", mem_addr | mem_wdata, 32'd0);
    exp_rd = 32'd0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bits;
    int n;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    apply_reset();

    // Store/load word on port 0.
    do_access(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
    do_access(0, 0, 2'd2, 0, 32'h10, 32'd0);
    check("t1_lw", rdata, 32'hDEAD_BEEF);

    // Byte store and signed/unsigned byte loads on port 1.
    do_access(1, 1, 2'd0, 0, 32'h20, 32'h80);
    do_access(1, 0, 2'd0, 0, 32'h20, 32'd0);
    check("t2_lb", rdata, 32'hFFFF_FF80);
    do_access(1, 0, 2'd0, 1, 32'h20, 32'd0);
    check("t2_lbu", rdata, 32'h0000_0080);
    do_access(1, 0, 2'd1, 0, 32'h20, 32'd0);

    // Round robin from reset with both ports requesting.
    apply_reset();
    both_req(4, bits, n);
    check("rr_count", n, 32'd4);
    check("rr_order", {28'd0, bits}, 32'b1010);
    exp_rd = ref_load(2'd2, 0, 32'h20);

    // Illegal accesses: misaligned half/word, out-of-range and size 11.
    do_access(0, 0, 2'd1, 0, 32'h3, 32'd0);
    do_access(0, 0, 2'd2, 0, 32'h6, 32'd0);
    do_access(0, 1, 2'd2, 0, 32'h1_0000, 32'h1234_5678);
    do_access(0, 1, 2'd3, 0, 32'h10, 32'h1234_5678);
    do_access(0, 0, 2'd2, 0, 32'h0, 32'd0);
    do_access(0, 0, 2'd2, 0, 32'h10, 32'd0);
    check("t4_unchanged", rdata, 32'hDEAD_BEEF);

    // Latency plus rdata held after done.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rdata_hold", rdata, 32'hDEAD_BEEF);
      check("no_done", {30'd0, done0, done1}, 32'd0);
    end

    // Reset in the middle of a store: strobes drop at once, no done, port 0 next.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; size0 = 2'd2; uns0 = 0; addr0 = 32'h40; wdata0 = 32'h1234_5678;
    @(posedge clk); #1;
    check("t5_in_access", {30'd0, mem_write}, {30'd0, WSw});
    rst_n = 0;
    #1;
    check("t5_strobes", {27'd0, mem_read, mem_write}, 32'd0);
    check("t5_gnt_addr", mem_addr | {31'd0, gnt0}, 32'd0);
    req0 = 0;
    exp_rd = 32'd0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_done", {30'd0, done0, done1}, 32'd0);
    end
    both_req(1, bits, n);
    check("t5_first_port0", {31'd0, bits[0]}, 32'd0);
    check("t5_grants", n, 32'd1);
    exp_rd = ref_load(2'd2, 0, 32'h10);
    do_access(1, 0, 2'd2, 0, 32'h40, 32'd0);
    check("t5_mem_intact", rdata, 32'd0);

    // Randomized single-port accesses against the reference model.
    for (int t = 0; t < 150; t++) begin
      int p = int'($urandom_range(0, 1));
      bit w = 1'($urandom_range(0, 1));
      logic [1:0] s = 2'($urandom_range(0, 3));
      logic u = 1'($urandom_range(0, 1));
      logic [31:0] a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      do_access(p, w, s, u, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
